// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with in-order commit and mispredict flush
// Define ROB_COMMIT_BYPASS_EN to let a CDB result for the head entry commit in the same cycle.
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      dec_ready,
  input  logic                      dec_has_rd,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic                      dec_is_branch,
  input  logic                      dec_pred_taken,
  input  logic [XLEN-1:0]           dec_alt_pc,
  input  logic                      cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_id,
  input  logic [XLEN-1:0]           cdb_val,
  input  logic                      cdb_taken,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  output logic                      rob_rf_enable,
  output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  output logic [XLEN-1:0]           rob_rf_val,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc
);

  localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0]   FULL_COUNT = (ROB_SIZE_WIDTH+1)'(ROB_SIZE);
  localparam logic [ROB_SIZE_WIDTH:0]   COUNT_ONE  = (ROB_SIZE_WIDTH+1)'(1);
  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE    = ROB_SIZE_WIDTH'(1);

  logic [ROB_SIZE_WIDTH-1:0] head;
  logic [ROB_SIZE_WIDTH-1:0] tail;
  logic [ROB_SIZE_WIDTH:0]   count;

  logic [ROB_SIZE-1:0]      busy;
  logic [ROB_SIZE-1:0]      done;
  logic [ROB_SIZE-1:0]      has_rd;
  logic [ROB_SIZE-1:0]      is_branch;
  logic [ROB_SIZE-1:0]      pred_taken;
  logic [ROB_SIZE-1:0]      taken;
  logic [REG_CNT_WIDTH-1:0] rd     [ROB_SIZE];
  logic [XLEN-1:0]          val    [ROB_SIZE];
  logic [XLEN-1:0]          alt_pc [ROB_SIZE];

  logic                     issue_fire;
  logic                     cdb_fire;
  logic                     head_ready;
  logic [XLEN-1:0]          head_val;
  logic                     head_taken;
  logic                     commit_fire;
  logic                     mispredict;
  logic [ROB_SIZE_WIDTH:0]  count_next;

  assign rob_full    = (count == FULL_COUNT);
  assign rob_head_id = head;
  assign rob_tail_id = tail;

  // A pending flush blocks issue, completion and commit for its one cycle.
  assign issue_fire = rdy && dec_ready && !rob_full && !flush;
  assign cdb_fire   = rdy && !flush && cdb_valid && busy[cdb_id];

`ifdef ROB_COMMIT_BYPASS_EN
  logic cdb_hits_head;
  assign cdb_hits_head = cdb_fire && (cdb_id == head);
  assign head_ready    = busy[head] && (done[head] || cdb_hits_head);
  assign head_val      = cdb_hits_head ? cdb_val   : val[head];
  assign head_taken    = cdb_hits_head ? cdb_taken : taken[head];
`else
  assign head_ready    = busy[head] && done[head];
  assign head_val      = val[head];
  assign head_taken    = taken[head];
`endif

  assign commit_fire = rdy && !flush && head_ready;
  assign mispredict  = commit_fire && is_branch[head] && (head_taken != pred_taken[head]);

  always_comb begin
    count_next = count;
    case ({issue_fire, commit_fire})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      done          <= '0;
      has_rd        <= '0;
      is_branch     <= '0;
      pred_taken    <= '0;
      taken         <= '0;
      rob_rf_enable <= 1'b0;
      rob_rf_rd     <= '0;
      rob_rf_val    <= '0;
      flush         <= 1'b0;
      flush_pc      <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd[i]     <= '0;
        val[i]    <= '0;
        alt_pc[i] <= '0;
      end
    end else if (rdy) begin
      rob_rf_enable <= 1'b0;
      flush         <= 1'b0;
      if (flush) begin
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (issue_fire) begin
          busy[tail]       <= 1'b1;
          done[tail]       <= 1'b0;
          has_rd[tail]     <= dec_has_rd;
          rd[tail]         <= dec_rd;
          is_branch[tail]  <= dec_is_branch;
          pred_taken[tail] <= dec_pred_taken;
          alt_pc[tail]     <= dec_alt_pc;
          tail             <= tail + PTR_ONE;
        end
        if (cdb_fire) begin
          done[cdb_id]  <= 1'b1;
          val[cdb_id]   <= cdb_val;
          taken[cdb_id] <= cdb_taken;
        end
        // Issue never targets the head slot here: that would require a full buffer.
        if (commit_fire) begin
          busy[head]    <= 1'b0;
          head          <= head + PTR_ONE;
          rob_rf_enable <= has_rd[head];
          if (has_rd[head]) begin
            rob_rf_rd  <= rd[head];
            rob_rf_val <= head_val;
          end
          if (mispredict) begin
            flush    <= 1'b1;
            flush_pc <= alt_pc[head];
          end
        end
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

`ifdef ROB_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        dec_ready;
  logic        dec_has_rd;
  logic [4:0]  dec_rd;
  logic        dec_is_branch;
  logic        dec_pred_taken;
  logic [31:0] dec_alt_pc;
  logic        cdb_valid;
  logic [2:0]  cdb_id;
  logic [31:0] cdb_val;
  logic        cdb_taken;
  logic        rob_full;
  logic [2:0]  rob_head_id;
  logic [2:0]  rob_tail_id;
  logic        rob_rf_enable;
  logic [4:0]  rob_rf_rd;
  logic [31:0] rob_rf_val;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_pass   = 0;

  reorder_buffer #(.ROB_SIZE_WIDTH(3), .XLEN(32), .REG_CNT_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .dec_ready      (dec_ready),
    .dec_has_rd     (dec_has_rd),
    .dec_rd         (dec_rd),
    .dec_is_branch  (dec_is_branch),
    .dec_pred_taken (dec_pred_taken),
    .dec_alt_pc     (dec_alt_pc),
    .cdb_valid      (cdb_valid),
    .cdb_id         (cdb_id),
    .cdb_val        (cdb_val),
    .cdb_taken      (cdb_taken),
    .rob_full       (rob_full),
    .rob_head_id    (rob_head_id),
    .rob_tail_id    (rob_tail_id),
    .rob_rf_enable  (rob_rf_enable),
    .rob_rf_rd      (rob_rf_rd),
    .rob_rf_val     (rob_rf_val),
    .flush          (flush),
    .flush_pc       (flush_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_ready      = 1'b0;
    dec_has_rd     = 1'b0;
    dec_rd         = '0;
    dec_is_branch  = 1'b0;
    dec_pred_taken = 1'b0;
    dec_alt_pc     = '0;
    cdb_valid      = 1'b0;
    cdb_id         = '0;
    cdb_val        = '0;
    cdb_taken      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic has_rd, input logic [4:0] rd, input logic is_br,
                       input logic pred, input logic [31:0] alt, input logic [2:0] exp_id);
    dec_ready      = 1'b1;
    dec_has_rd     = has_rd;
    dec_rd         = rd;
    dec_is_branch  = is_br;
    dec_pred_taken = pred;
    dec_alt_pc     = alt;
    check("issue_id", rob_tail_id, exp_id);
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] v, input logic tk);
    cdb_valid = 1'b1;
    cdb_id    = id;
    cdb_val   = v;
    cdb_taken = tk;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rdy = 1'b1;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_head", rob_head_id, 0);
    check("rst_tail", rob_tail_id, 0);
    check("rst_full", rob_full, 0);
    check("rst_rf_en", rob_rf_enable, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);
    rst = 1'b0;

    // three issues with rd 1..3
    for (int i = 0; i < 3; i++) issue(1'b1, 5'(i + 1), 1'b0, 1'b0, 32'h0, 3'(i));
    check("s1_tail", rob_tail_id, 3);
    check("s1_count", dut.count, 3);
    check("s1_head", rob_head_id, 0);

    // out-of-order completion, in-order commit
    cdb(3'd1, 32'hB1, 1'b0);
    check("ooo_no_commit", rob_rf_enable, 0);
    check("ooo_head", rob_head_id, 0);
    cdb(3'd0, 32'hA0, 1'b0);
`ifndef ROB_COMMIT_BYPASS_EN
    check("no_same_cycle", rob_rf_enable, 0);
    tick();
`endif
    check("c1_en", rob_rf_enable, 1);
    check("c1_rd", rob_rf_rd, 1);
    check("c1_val", rob_rf_val, 32'hA0);
    check("c1_head", rob_head_id, 1);
    rdy = 1'b0;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("hold_en", rob_rf_enable, 1);
    check("hold_head", rob_head_id, 1);
    check("hold_tail", rob_tail_id, 3);
    rdy = 1'b1;
    tick();
    check("c2_en", rob_rf_enable, 1);
    check("c2_rd", rob_rf_rd, 2);
    check("c2_val", rob_rf_val, 32'hB1);
    check("c2_head", rob_head_id, 2);
    tick();
    check("c2_pulse", rob_rf_enable, 0);
    cdb(3'd2, 32'hC2, 1'b0);
`ifndef ROB_COMMIT_BYPASS_EN
    tick();
`endif
    check("c3_rd", rob_rf_rd, 3);
    check("c3_val", rob_rf_val, 32'hC2);
    check("c3_count", dut.count, 0);

    // fill to full, then reject
    do_reset();
    for (int i = 0; i < 8; i++) issue(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 3'(i));
    check("full_flag", rob_full, 1);
    check("full_tail", rob_tail_id, 0);
    dec_ready = 1'b1;
    tick();
    check("full_reject_tail", rob_tail_id, 0);
    check("full_reject_count", dut.count, 8);
    cdb_valid = 1'b1;
    cdb_id    = 3'd0;
    tick();
    cdb_valid = 1'b0;
    tick();
    dec_ready = 1'b0;
    check("full_commit_head", rob_head_id, 1);
    check("full_commit_tail", rob_tail_id, BYP ? 1 : 0);
    check("full_commit_count", dut.count, BYP ? 8 : 7);

    // branch mispredict flush
    do_reset();
    issue(1'b0, 5'd0, 1'b1, 1'b0, 32'h100, 3'd0);
    issue(1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 3'd1);
    issue(1'b1, 5'd6, 1'b0, 1'b0, 32'h0, 3'd2);
    cdb(3'd0, 32'h0, 1'b1);
`ifndef ROB_COMMIT_BYPASS_EN
    check("flush_not_early", flush, 0);
    tick();
`endif
    check("flush_hi", flush, 1);
    check("flush_pc", flush_pc, 32'h100);
    check("flush_rf_en", rob_rf_enable, 0);
    cdb_valid = 1'b1;
    cdb_id    = 3'd1;
    cdb_val   = 32'h55;
    dec_ready = 1'b1;
    dec_has_rd = 1'b1;
    dec_rd    = 5'd7;
    tick();
    idle_inputs();
    check("flush_pulse", flush, 0);
    check("flush_head", rob_head_id, 0);
    check("flush_tail", rob_tail_id, 0);
    check("flush_count", dut.count, 0);
    cdb(3'd1, 32'h66, 1'b0);
    tick();
    check("flush_cdb_ignored", rob_rf_enable, 0);
    check("flush_head_after", rob_head_id, 0);

    // head at id 4: commit latency
    do_reset();
    for (int i = 0; i < 5; i++) issue(1'b1, 5'(i + 1), 1'b0, 1'b0, 32'h0, 3'(i));
    for (int i = 0; i < 4; i++) cdb(3'(i), 32'(i), 1'b0);
    tick();
    tick();
    check("h4_head", rob_head_id, 4);
    check("h4_idle", rob_rf_enable, 0);
    cdb(3'd4, 32'h44, 1'b0);
    check("h4_commit_n", rob_rf_enable, BYP);
    tick();
    check("h4_commit_n1", rob_rf_enable, !BYP);
    check("h4_head_after", rob_head_id, 5);
    check("h4_val", rob_rf_val, 32'h44);
    check("h4_rd", rob_rf_rd, 5);

    // reset between edges while flush is pending
    do_reset();
    issue(1'b1, 5'd9, 1'b1, 1'b1, 32'h200, 3'd0);
    cdb(3'd0, 32'h77, 1'b0);
`ifndef ROB_COMMIT_BYPASS_EN
    tick();
`endif
    check("pre_rst_flush", flush, 1);
    check("pre_rst_rf_en", rob_rf_enable, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_flush", flush, 0);
    check("mid_rst_rf_en", rob_rf_enable, 0);
    check("mid_rst_flush_pc", flush_pc, 0);
    check("mid_rst_head", rob_head_id, 0);
    check("mid_rst_tail", rob_tail_id, 0);
    tick();
    rst = 1'b0;
    issue(1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 3'd0);
    check("post_rst_tail", rob_tail_id, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE_WIDTH, default 3, log2 of entry count (8 entries).
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter REG_CNT_WIDTH, default 5, architectural register index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port rdy, input, 1, global enable; when low, no state changes.
REQ-007 SHALL have port dec_ready, input, 1, decoder presents an instruction this cycle.
REQ-008 SHALL have ports dec_has_rd (1) and dec_rd (REG_CNT_WIDTH), inputs, destination-write flag and index.
REQ-009 SHALL have ports dec_is_branch (1), dec_pred_taken (1) and dec_alt_pc (XLEN), inputs, branch flag, predicted direction and recovery PC.
REQ-010 SHALL have ports cdb_valid (1), cdb_id (ROB_SIZE_WIDTH), cdb_val (XLEN) and cdb_taken (1), inputs, result broadcast.
REQ-011 SHALL have ports rob_full (1), rob_head_id (ROB_SIZE_WIDTH) and rob_tail_id (ROB_SIZE_WIDTH), outputs, occupancy and pointers.
REQ-012 SHALL have ports rob_rf_enable (1), rob_rf_rd (REG_CNT_WIDTH) and rob_rf_val (XLEN), outputs, registered commit write to the register file.
REQ-013 SHALL have ports flush (1) and flush_pc (XLEN), outputs, registered mispredict recovery pulse and target.

Function
REQ-014 SHALL hold per entry: busy, done, has_rd, rd, val, is_branch, pred_taken, taken, alt_pc; circular buffer of 2^ROB_SIZE_WIDTH entries.
REQ-015 SHALL keep an occupancy counter of ROB_SIZE_WIDTH+1 bits; rob_full = (count == 2^ROB_SIZE_WIDTH), combinational from registers.
REQ-016 SHALL accept issue when dec_ready && !rob_full && !flush: write entry at tail (busy=1, done=0), tail <= tail+1 (wraps modulo size); rob_tail_id is the id given to the issuing instruction.
REQ-017 SHALL, on cdb_valid with busy[cdb_id], set done=1, val=cdb_val, taken=cdb_taken; ignored if entry not busy.
REQ-018 SHALL commit at most one entry per cycle: when head entry busy && done, clear busy and advance head, so rob_head_id-1 equals the committed id in the cycle rob_rf_enable is high.
REQ-019 SHALL assert rob_rf_enable for exactly one cycle after commit when has_rd, driving rob_rf_rd=rd, rob_rf_val=val; otherwise 0.
REQ-020 SHALL, when committing a branch with taken != pred_taken, assert flush one cycle later with flush_pc=alt_pc.
REQ-021 SHALL, in the cycle flush is high, ignore issue and CDB, clear all busy bits and set head=tail=0, count=0.
REQ-022 SHALL leave count unchanged on simultaneous issue and commit; a full buffer rejects issue even if a commit occurs that cycle.
REQ-023 SHALL not let a CDB write to the head entry commit in the same cycle (default build); commit follows next cycle.
REQ-024 SHALL, with rdy low, hold every register including rob_rf_enable and flush.

Reset
REQ-025 SHALL, on rst high, asynchronously clear head, tail, count, all busy/done bits, rob_rf_enable, rob_rf_rd, rob_rf_val, flush, flush_pc to 0.
REQ-026 SHALL discard any in-flight commit or flush when reset asserts mid-operation; first valid issue after release gets id 0.

Configuration
REQ-027 SHALL honour macro ROB_COMMIT_BYPASS_EN: when defined, a head entry receiving cdb_valid with cdb_id==head commits that same cycle using cdb_val/cdb_taken; when undefined, behaviour per REQ-023.

Verification
REQ-028 SHALL cover: reset, issue 3 instrs rd=1,2,3 -> ids 0,1,2, rob_tail_id=3, count=3.
REQ-029 SHALL cover: CDB completes id 1 before id 0 -> no commit until id 0 completes; then x1, x2 written on consecutive cycles in order.
REQ-030 SHALL cover: issue 8 without completion -> rob_full=1, 9th dec_ready rejected, tail stays 0 (wrapped).
REQ-031 SHALL cover: branch id 0 pred_taken=0, CDB taken=1, alt_pc=0x100 -> flush=1 one cycle, flush_pc=0x100, head=tail=0, younger CDB results ignored.
REQ-032 SHALL cover: CDB for head id 4 in cycle N -> commit at N+1 without ROB_COMMIT_BYPASS_EN, at N with it.
REQ-033 SHALL cover: rst asserted between edges while flush pending -> flush and rob_rf_enable drop immediately, pointers 0.
